jpeg_bs_parser: RTL and testbench
=================================

// Module: jpeg_bs_parser
// PURPOSE
//  Receive-side front end for the JPEG byte stream produced by the encoder (data_valid/data_out).
//  - Hunts SOI, parses SOF0 for picture size, skips the other segments by their length, and enters entropy-coded-segment (ECS) mode after SOS.
//  - In ECS mode it removes 0xFF00 byte stuffing and queues ECS bytes and marker tokens for the entropy decoder.
//  - The byte input has no backpressure; buffering toward the decoder uses a ready/valid FIFO.
// PARAMETERS
//  FIFO_DEPTH  16  ECS token FIFO entries, power of 2, minimum 4
//  W_DIM       16  width of pic_width/pic_height
// PORTS
//  clk                in   1      single clock, all logic
//  rst                in   1      synchronous, active-high reset
//  data_valid_i       in   1      input byte strobe, no backpressure
//  data_i             in   8      input byte
//  ecs_valid          out  1      FIFO head valid
//  ecs_ready          in   1      decoder accepts head (pop when valid&ready)
//  ecs_data           out  8      ECS byte, or marker code when ecs_marker=1
//  ecs_marker         out  1      head is a marker token (D0..D7 restart, D9 EOI)
//  pic_start          out  1      1-cycle pulse on SOI
//  sof_valid          out  1      1-cycle pulse when SOF0 height/width are captured
//  pic_height         out  W_DIM  SOF0 height, held until next SOF0
//  pic_width          out  W_DIM  SOF0 width, held until next SOF0
//  ecs_active         out  1      1 while in ECS mode
//  err_fifo_overflow  out  1      sticky; cleared by rst or SOI
//  err_syntax         out  1      sticky; cleared by rst or SOI
// BEHAVIOUR
//  Reset: every output is 0, FIFO is empty, FSM is HUNT. Reset mid-stream discards all state the next cycle.
//  FSM (advances only on data_valid_i):
//   - HUNT: FF->HUNT_FF, else stay. HUNT_FF: D8->MARK_WAIT plus pic_start, FF stay, else HUNT.
//   - MARK_WAIT: expect FF->MARK. MARK: FF stay (fill byte).
//     - D8/D9 in MARK -> err_syntax, go to HUNT.
//     - Any other code -> LEN_H, latching the code.
//   - LEN_H/LEN_L: 16-bit segment length L.
//     - L<2 -> err_syntax, go to HUNT.
//     - Otherwise remaining = L-2 and go to BODY; if remaining=0, go straight to MARK_WAIT (or ECS for SOS).
//   - BODY: decrement remaining per byte.
//     - If code=C0, body offsets 1..4 load height hi/lo and width hi/lo.
//     - sof_valid pulses the cycle after the width lo byte.
//     - At remaining=0: code DA -> ECS, else MARK_WAIT.
//     - SOF0 with L<8 -> err_syntax, go to HUNT.
//   - ECS: non-FF byte -> push {0,byte}; FF -> ECS_FF.
//   - ECS_FF:
//     - 00 -> push {0,FF}, back to ECS.
//     - FF -> stay (fill byte).
//     - D0..D7 -> push {1,code}, back to ECS.
//     - D9 -> push {1,D9}, go to HUNT.
//     - Any other code -> err_syntax, go to HUNT, nothing pushed.
//  Latency: a byte pushed at input cycle t has ecs_valid=1 at t+1 if the FIFO was empty (registered write, fall-through read).
//  FIFO rules:
//   - Simultaneous push and pop is legal at any fill level, including full.
//   - Push while full without a pop drops the token and sets err_fifo_overflow.
//   - Pop while empty is ignored.
//  A stuffed pair is a single token; it is pushed on the 00 byte.
//  SOI while in ECS: not a special case; ECS_FF treats D8 as any other code -> err_syntax. Only HUNT_FF restarts.
//  ecs_active is 1 in ECS and ECS_FF.
// CONFIGURATION
//  JPEG_BSP_BYTECNT_EN
//   - Defined: adds output ecs_byte_cnt[31:0], counting popped non-marker tokens.
//   - The counter clears on pic_start and is held after the EOI token is popped.
//   - Undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  - jpeg_global.v: marker codes M_SOI=D8, M_EOI=D9, M_SOF0=C0, M_SOS=DA, M_RST0=D0; FSM state encodings; W_DIM default.
//  - Sub-module jpeg_bs_fifo: synchronous FIFO, 9-bit data, fall-through read, full/empty outputs.
//  - FSM, length counter and SOF capture stay in this module.
// TESTING
//  1. Feed the stream below with ecs_ready=1:
//     FFD8 | FFC0 0011 08 0010 0020 03 +9 bytes | FFDA 0008 +6 bytes | 12 FF 00 34 | FFD9
//     Expected:
//     - pic_start pulses once.
//     - sof_valid pulses with height=16 and width=32.
//     - Tokens, in order: {0,12} {0,FF} {0,34} {1,D9}.
//     - No errors.
//  2. ECS input "56 FF D3 78" -> tokens {0,56} {1,D3} {0,78}.
//  3. ecs_ready=0 with 20 plain ECS bytes, FIFO_DEPTH=16 -> 16 tokens held, err_fifo_overflow=1.
//     Releasing ready yields exactly the first 16 bytes in order.
//  4. ECS input "FF FF FF D9" -> exactly one {1,D9} token, FSM in HUNT, ecs_active=0.
//  5. After FFD8, segment "FFDB 0001" -> err_syntax=1 and FSM in HUNT.
//     A following FFD8 -> pic_start pulses and err_syntax clears.
//  6. Assert rst for 1 cycle mid-ECS with 5 tokens queued -> next cycle ecs_valid=0, ecs_active=0, errors 0.
//     Bytes after reset that precede SOI produce no tokens.

Source files
------------

// File: rtl/jpeg_bs_parser_pkg.sv
// Shared definitions for the JPEG byte-stream parser: marker codes, FSM
// states, the ECS token layout and a restart-marker helper.
package jpeg_bs_parser_pkg;

  localparam logic [7:0] M_SOI   = 8'hD8;
  localparam logic [7:0] M_EOI   = 8'hD9;
  localparam logic [7:0] M_SOF0  = 8'hC0;
  localparam logic [7:0] M_SOS   = 8'hDA;
  localparam logic [7:0] M_RST0  = 8'hD0;
  localparam logic [7:0] M_FF    = 8'hFF;
  localparam logic [7:0] M_STUFF = 8'h00;

  localparam int W_DIM_DEFAULT = 16;

  typedef enum logic [3:0] {
    ST_HUNT,
    ST_HUNT_FF,
    ST_MARK_WAIT,
    ST_MARK,
    ST_LEN_H,
    ST_LEN_L,
    ST_BODY,
    ST_ECS,
    ST_ECS_FF
  } bsp_state_e;

  // One FIFO entry: marker flag above the byte / marker code.
  typedef struct packed {
    logic       marker;
    logic [7:0] code;
  } ecs_token_t;

  // True for RST0..RST7 (D0..D7).
  function automatic logic is_rst_marker(input logic [7:0] c);
    return (c[7:3] == M_RST0[7:3]);
  endfunction

endpackage

// File: rtl/jpeg_bs_fifo.sv
// Synchronous FIFO with registered write and fall-through read.
// Push while full is accepted only if a pop happens in the same cycle;
// otherwise the token is dropped and o-side 'drop' flags it for one cycle.
module jpeg_bs_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic         full,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_pop_ok;
  logic         w_push_ok;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign drop      = push && full && !w_pop_ok;
  assign head_data = r_mem[r_rd_ptr[AW-1:0]];

  // Storage write; when full with a pop, the slot written is the one being read out.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointer update, one extra bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/jpeg_bs_parser.sv
// JPEG byte-stream front end: hunts SOI, captures SOF0 size, skips segments
// by length, and in entropy-coded mode removes 0xFF00 stuffing and queues
// ECS bytes / RST / EOI tokens for the decoder.
// Optional feature macro: JPEG_BSP_BYTECNT_EN adds ecs_byte_cnt, a count of
// popped non-marker tokens (cleared on SOI, frozen once EOI is popped).
module jpeg_bs_parser
  import jpeg_bs_parser_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int W_DIM      = W_DIM_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid_i,
  input  logic [7:0]       data_i,
  output logic             ecs_valid,
  input  logic             ecs_ready,
  output logic [7:0]       ecs_data,
  output logic             ecs_marker,
  output logic             pic_start,
  output logic             sof_valid,
  output logic [W_DIM-1:0] pic_height,
  output logic [W_DIM-1:0] pic_width,
  output logic             ecs_active,
  output logic             err_fifo_overflow,
`ifdef JPEG_BSP_BYTECNT_EN
  output logic [31:0]      ecs_byte_cnt,
`endif
  output logic             err_syntax
);

  bsp_state_e  r_state;
  logic [7:0]  r_code;
  logic [7:0]  r_len_hi;
  logic [15:0] r_remaining;
  logic [2:0]  r_body_idx;
  logic        r_pic_start;
  logic        r_sof_valid;
  logic [15:0] r_height;
  logic [15:0] r_width;
  logic        r_err_ovf;
  logic        r_err_syn;

  logic        w_push;
  ecs_token_t  w_push_tok;
  ecs_token_t  w_head;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic        w_drop;
  logic        w_soi;
  logic [15:0] w_len;

  assign w_len      = {r_len_hi, data_i};
  assign w_soi      = data_valid_i && (r_state == ST_HUNT_FF) && (data_i == M_SOI);
  assign ecs_valid  = !w_empty;
  assign w_pop      = ecs_valid && ecs_ready;
  assign ecs_data   = w_head.code;
  assign ecs_marker = w_head.marker;
  assign ecs_active = (r_state == ST_ECS) || (r_state == ST_ECS_FF);
  assign pic_start  = r_pic_start;
  assign sof_valid  = r_sof_valid;
  assign pic_height = W_DIM'(r_height);
  assign pic_width  = W_DIM'(r_width);
  assign err_fifo_overflow = r_err_ovf;
  assign err_syntax        = r_err_syn;

  // Token decode in ECS mode; the stuffed pair becomes one token on its 00 byte.
  always_comb begin
    w_push     = 1'b0;
    w_push_tok = '0;
    if (data_valid_i) begin
      case (r_state)
        ST_ECS: begin
          if (data_i != M_FF) begin
            w_push     = 1'b1;
            w_push_tok = '{marker: 1'b0, code: data_i};
          end
        end
        ST_ECS_FF: begin
          if (data_i == M_STUFF) begin
            w_push     = 1'b1;
            w_push_tok = '{marker: 1'b0, code: M_FF};
          end else if (is_rst_marker(data_i) || data_i == M_EOI) begin
            w_push     = 1'b1;
            w_push_tok = '{marker: 1'b1, code: data_i};
          end
        end
        default: ;
      endcase
    end
  end

  jpeg_bs_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (9)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_tok),
    .pop       (w_pop),
    .head_data (w_head),
    .empty     (w_empty),
    .full      (w_full),
    .drop      (w_drop)
  );

  // Marker/segment FSM with length counter, SOF0 capture and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_code      <= '0;
      r_len_hi    <= '0;
      r_remaining <= '0;
      r_body_idx  <= '0;
      r_pic_start <= 1'b0;
      r_sof_valid <= 1'b0;
      r_height    <= '0;
      r_width     <= '0;
      r_err_ovf   <= 1'b0;
      r_err_syn   <= 1'b0;
    end else begin
      r_pic_start <= 1'b0;
      r_sof_valid <= 1'b0;
      if (w_drop) r_err_ovf <= 1'b1;
      if (data_valid_i) begin
        case (r_state)
          ST_HUNT: begin
            if (data_i == M_FF) r_state <= ST_HUNT_FF;
          end
          ST_HUNT_FF: begin
            if (data_i == M_SOI) begin
              r_state     <= ST_MARK_WAIT;
              r_pic_start <= 1'b1;
              r_err_ovf   <= 1'b0;
              r_err_syn   <= 1'b0;
            end else if (data_i != M_FF) begin
              r_state <= ST_HUNT;
            end
          end
          ST_MARK_WAIT: begin
            if (data_i == M_FF) begin
              r_state <= ST_MARK;
            end else begin
              r_err_syn <= 1'b1;
              r_state   <= ST_HUNT;
            end
          end
          ST_MARK: begin
            if (data_i == M_SOI || data_i == M_EOI) begin
              r_err_syn <= 1'b1;
              r_state   <= ST_HUNT;
            end else if (data_i != M_FF) begin
              r_code  <= data_i;
              r_state <= ST_LEN_H;
            end
          end
          ST_LEN_H: begin
            r_len_hi <= data_i;
            r_state  <= ST_LEN_L;
          end
          ST_LEN_L: begin
            if (w_len < 16'd2 || (r_code == M_SOF0 && w_len < 16'd8)) begin
              r_err_syn <= 1'b1;
              r_state   <= ST_HUNT;
            end else begin
              r_remaining <= w_len - 16'd2;
              r_body_idx  <= '0;
              if (w_len == 16'd2) begin
                r_state <= (r_code == M_SOS) ? ST_ECS : ST_MARK_WAIT;
              end else begin
                r_state <= ST_BODY;
              end
            end
          end
          ST_BODY: begin
            r_remaining <= r_remaining - 16'd1;
            if (r_body_idx != 3'd7) r_body_idx <= r_body_idx + 3'd1;
            if (r_code == M_SOF0) begin
              case (r_body_idx)
                3'd1: r_height[15:8] <= data_i;
                3'd2: r_height[7:0]  <= data_i;
                3'd3: r_width[15:8]  <= data_i;
                3'd4: begin
                  r_width[7:0] <= data_i;
                  r_sof_valid  <= 1'b1;
                end
                default: ;
              endcase
            end
            if (r_remaining == 16'd1) begin
              r_state <= (r_code == M_SOS) ? ST_ECS : ST_MARK_WAIT;
            end
          end
          ST_ECS: begin
            if (data_i == M_FF) r_state <= ST_ECS_FF;
          end
          ST_ECS_FF: begin
            if (data_i == M_STUFF || is_rst_marker(data_i)) begin
              r_state <= ST_ECS;
            end else if (data_i == M_EOI) begin
              r_state <= ST_HUNT;
            end else if (data_i != M_FF) begin
              r_err_syn <= 1'b1;
              r_state   <= ST_HUNT;
            end
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

`ifdef JPEG_BSP_BYTECNT_EN
  logic [31:0] r_byte_cnt;
  logic        r_cnt_hold;

  assign ecs_byte_cnt = r_byte_cnt;

  // Count popped data tokens for the current picture; freeze after EOI leaves the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_cnt_hold <= 1'b0;
    end else if (w_soi) begin
      r_byte_cnt <= '0;
      r_cnt_hold <= 1'b0;
    end else if (w_pop) begin
      if (w_head.marker) begin
        if (w_head.code == M_EOI) r_cnt_hold <= 1'b1;
      end else if (!r_cnt_hold) begin
        r_byte_cnt <= r_byte_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jpeg_bs_parser.sv
// Self-checking bench for jpeg_bs_parser: directed scenarios plus randomized
// pictures whose expected token list is derived from how the stream was built.
module tb_jpeg_bs_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_valid_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        ecs_valid;
  logic        ecs_ready = 1'b0;
  logic [7:0]  ecs_data;
  logic        ecs_marker;
  logic        pic_start;
  logic        sof_valid;
  logic [15:0] pic_height;
  logic [15:0] pic_width;
  logic        ecs_active;
  logic        err_fifo_overflow;
  logic        err_syntax;
`ifdef JPEG_BSP_BYTECNT_EN
  logic [31:0] ecs_byte_cnt;
`endif

  jpeg_bs_parser #(.FIFO_DEPTH(16), .W_DIM(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .data_valid_i      (data_valid_i),
    .data_i            (data_i),
    .ecs_valid         (ecs_valid),
    .ecs_ready         (ecs_ready),
    .ecs_data          (ecs_data),
    .ecs_marker        (ecs_marker),
    .pic_start         (pic_start),
    .sof_valid         (sof_valid),
    .pic_height        (pic_height),
    .pic_width         (pic_width),
    .ecs_active        (ecs_active),
    .err_fifo_overflow (err_fifo_overflow),
`ifdef JPEG_BSP_BYTECNT_EN
    .ecs_byte_cnt      (ecs_byte_cnt),
`endif
    .err_syntax        (err_syntax)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side state
  logic [7:0]  stim[$];
  logic [8:0]  exp_q[$];
  logic [8:0]  got_q[$];
  int          got_rd = 0;
  int          n_pic = 0;
  int          n_sof = 0;
  int          base_pic = 0;
  int          base_sof = 0;
  logic [15:0] sof_h = '0;
  logic [15:0] sof_w = '0;
  int          ready_mode = 0;   // 0: hold off, 1: always ready, 2: random
  bit          gap_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Decoder-side ready generation
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       ecs_ready = 1'b0;
      1:       ecs_ready = 1'b1;
      default: ecs_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: one sample per cycle, between edges
  always @(negedge clk) begin
    if (!rst) begin
      if (ecs_valid && ecs_ready) got_q.push_back({ecs_marker, ecs_data});
      if (pic_start) n_pic++;
      if (sof_valid) begin
        n_sof++;
        sof_h = pic_height;
        sof_w = pic_width;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    if (gap_en && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
      data_valid_i = 1'b0;
      data_i = 8'($urandom);
    end
    @(posedge clk); #1;
    data_valid_i = 1'b1;
    data_i = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      data_valid_i = 1'b0;
    end
  endtask

  task automatic flush_stim();
    for (int i = 0; i < stim.size(); i++) send(stim[i]);
    stim.delete();
    idle(2);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    data_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    got_rd   = got_q.size();
    base_pic = n_pic;
    base_sof = n_sof;
    exp_q.delete();
  endtask

  // SOI followed directly by an empty SOS: lands in ECS with no body bytes.
  task automatic add_min_header();
    stim.push_back(8'hFF); stim.push_back(8'hD8);
    stim.push_back(8'hFF); stim.push_back(8'hDA);
    stim.push_back(8'h00); stim.push_back(8'h02);
  endtask

  // SOI, random skipped segments, SOF0 with the given size, SOS.
  task automatic add_full_header(input logic [15:0] h, input logic [15:0] w);
    logic [7:0] codes[6] = '{8'hE0, 8'hDB, 8'hC4, 8'hFE, 8'hE1, 8'hDD};
    int nseg;
    int blen;
    stim.push_back(8'hFF); stim.push_back(8'hD8);
    nseg = $urandom_range(0, 3);
    for (int s = 0; s < nseg; s++) begin
      blen = $urandom_range(0, 5);
      stim.push_back(8'hFF);
      if ($urandom_range(0, 2) == 0) stim.push_back(8'hFF);
      stim.push_back(codes[$urandom_range(0, 5)]);
      stim.push_back(8'h00); stim.push_back(8'(blen + 2));
      for (int k = 0; k < blen; k++) stim.push_back(8'($urandom));
    end
    stim.push_back(8'hFF); stim.push_back(8'hC0);
    stim.push_back(8'h00); stim.push_back(8'h11);
    stim.push_back(8'h08);
    stim.push_back(h[15:8]); stim.push_back(h[7:0]);
    stim.push_back(w[15:8]); stim.push_back(w[7:0]);
    stim.push_back(8'h03);
    for (int k = 0; k < 9; k++) stim.push_back(8'($urandom));
    stim.push_back(8'hFF); stim.push_back(8'hDA);
    stim.push_back(8'h00); stim.push_back(8'h08);
    for (int k = 0; k < 6; k++) stim.push_back(8'($urandom));
  endtask

  // Wait (bounded) for the expected tokens, then compare count and order.
  task automatic drain_check(input string tag);
    int waited = 0;
    int n_got;
    while ((got_q.size() - got_rd) < exp_q.size() && waited < 1000) begin
      @(posedge clk);
      waited++;
    end
    repeat (4) @(posedge clk);
    n_got = got_q.size() - got_rd;
    check($sformatf("%s_ntok", tag), n_got, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < n_got) check($sformatf("%s_tok%0d", tag, i), got_q[got_rd + i], exp_q[i]);
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] h;
    logic [15:0] w;
    logic [7:0]  b;
    int          ntok;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_ecs_valid", ecs_valid, 0);
    check("rst_pic_start", pic_start, 0);
    check("rst_sof_valid", sof_valid, 0);
    check("rst_dims", {pic_height, pic_width}, 0);
    check("rst_ecs_active", ecs_active, 0);
    check("rst_errs", {err_fifo_overflow, err_syntax}, 0);

    // 1: reference picture, decoder always ready
    ready_mode = 1;
    do_reset();
    add_full_header(16'd16, 16'd32);
    stim.push_back(8'h12); stim.push_back(8'hFF); stim.push_back(8'h00);
    stim.push_back(8'h34); stim.push_back(8'hFF); stim.push_back(8'hD9);
    exp_q = '{9'h012, 9'h0FF, 9'h034, 9'h1D9};
    flush_stim();
    drain_check("t1");
    check("t1_pic_start", n_pic - base_pic, 1);
    check("t1_sof_cnt", n_sof - base_sof, 1);
    check("t1_height", sof_h, 16);
    check("t1_width", sof_w, 32);
    check("t1_errs", {err_fifo_overflow, err_syntax}, 0);
    check("t1_ecs_active", ecs_active, 0);
`ifdef JPEG_BSP_BYTECNT_EN
    check("t1_byte_cnt", ecs_byte_cnt, 3);
`endif

    // 2: restart marker inside ECS
    do_reset();
    add_min_header();
    stim.push_back(8'h56); stim.push_back(8'hFF); stim.push_back(8'hD3);
    stim.push_back(8'h78); stim.push_back(8'hFF); stim.push_back(8'hD9);
    exp_q = '{9'h056, 9'h1D3, 9'h078, 9'h1D9};
    flush_stim();
    drain_check("t2");
    check("t2_errs", {err_fifo_overflow, err_syntax}, 0);

    // 3: overflow with decoder stalled
    ready_mode = 0;
    do_reset();
    add_min_header();
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 254));
      stim.push_back(b);
      if (i < 16) exp_q.push_back({1'b0, b});
    end
    flush_stim();
    idle(2);
    check("t3_no_pop", got_q.size() - got_rd, 0);
    check("t3_valid_full", ecs_valid, 1);
    check("t3_overflow", err_fifo_overflow, 1);
    check("t3_syntax", err_syntax, 0);
    ready_mode = 1;
    drain_check("t3");
    check("t3_empty_after", ecs_valid, 0);

    // 4: fill bytes before EOI
    do_reset();
    add_min_header();
    stim.push_back(8'hFF); stim.push_back(8'hFF);
    stim.push_back(8'hFF); stim.push_back(8'hD9);
    exp_q = '{9'h1D9};
    flush_stim();
    drain_check("t4");
    check("t4_ecs_active", ecs_active, 0);
    check("t4_errs", {err_fifo_overflow, err_syntax}, 0);

    // 5: bad segment length, restart on SOI, short SOF0, SOI inside ECS
    do_reset();
    stim = '{8'hFF, 8'hD8, 8'hFF, 8'hDB, 8'h00, 8'h01};
    flush_stim();
    check("t5_len_err", err_syntax, 1);
    check("t5_ecs_active", ecs_active, 0);
    stim = '{8'hFF, 8'hD8};
    flush_stim();
    check("t5_resoi_pic", n_pic - base_pic, 2);
    check("t5_resoi_clr", err_syntax, 0);
    stim = '{8'hFF, 8'hC0, 8'h00, 8'h07};
    flush_stim();
    check("t5_sof_short", err_syntax, 1);
    check("t5_sof_none", n_sof - base_sof, 0);
    do_reset();
    add_min_header();
    stim.push_back(8'hAB); stim.push_back(8'hFF); stim.push_back(8'hD8);
    exp_q = '{9'h0AB};
    flush_stim();
    drain_check("t5_ecs");
    check("t5_ecs_soi_err", err_syntax, 1);
    check("t5_ecs_soi_pic", n_pic - base_pic, 1);
    check("t5_ecs_inactive", ecs_active, 0);

    // 6: reset mid-ECS with tokens queued
    ready_mode = 0;
    do_reset();
    add_min_header();
    for (int i = 0; i < 5; i++) stim.push_back(8'(8'h10 + i));
    flush_stim();
    check("t6_queued", ecs_valid, 1);
    check("t6_active", ecs_active, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("t6_valid_after_rst", ecs_valid, 0);
    check("t6_active_after_rst", ecs_active, 0);
    check("t6_errs_after_rst", {err_fifo_overflow, err_syntax}, 0);
    got_rd = got_q.size();
    ready_mode = 1;
    stim = '{8'h12, 8'h34, 8'hFF, 8'h00, 8'h56, 8'hFF, 8'hD0, 8'h78};
    flush_stim();
    idle(4);
    check("t6_no_tokens", got_q.size() - got_rd, 0);

    // Randomized pictures
    for (int t = 0; t < 10; t++) begin
      ready_mode = (t % 2 == 0) ? 1 : 2;
      gap_en = 1'b1;
      do_reset();
      h = 16'($urandom);
      w = 16'($urandom);
      add_full_header(h, w);
      ntok = (ready_mode == 2) ? $urandom_range(3, 10) : $urandom_range(10, 40);
      for (int i = 0; i < ntok; i++) begin
        if ($urandom_range(0, 6) == 0) begin
          b = 8'(8'hD0 + $urandom_range(0, 7));
          stim.push_back(8'hFF);
          if ($urandom_range(0, 2) == 0) stim.push_back(8'hFF);
          stim.push_back(b);
          exp_q.push_back({1'b1, b});
        end else begin
          b = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
          stim.push_back(b);
          if (b == 8'hFF) stim.push_back(8'h00);
          exp_q.push_back({1'b0, b});
        end
      end
      stim.push_back(8'hFF); stim.push_back(8'hD9);
      exp_q.push_back(9'h1D9);
      flush_stim();
      gap_en = 1'b0;
      drain_check($sformatf("rnd%0d", t));
      check($sformatf("rnd%0d_pic", t), n_pic - base_pic, 1);
      check($sformatf("rnd%0d_sof", t), n_sof - base_sof, 1);
      check($sformatf("rnd%0d_dims", t), {sof_h, sof_w}, {h, w});
      check($sformatf("rnd%0d_errs", t), {err_fifo_overflow, err_syntax, ecs_active}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
